// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller driven by a mid-bit baud sample pulse
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic       PAR_EN   = (PARITY_EN != 0);
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic [3:0]            r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bit;

    logic                  w_fall;
    logic                  w_par_bad;

    assign w_fall    = r_prev & ~r_sync2;
    assign w_par_bad = PAR_EN & (r_par_bit != ((^r_shift) ^ PAR_ODD));

    // Synchroniser and edge flops idle high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            bps_start  <= 1'b0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_START;
                        bps_start <= 1'b1;
                        rx_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (clk_bps) begin
                        if (!r_sync2) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 4'd0;
                        end else begin
                            r_state   <= S_IDLE;
                            bps_start <= 1'b0;
                            rx_busy   <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (clk_bps) begin
                        r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == LAST_BIT)
                            r_state <= PAR_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (clk_bps) begin
                        r_par_bit <= r_sync2;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Frame ends at mid stop bit so a back-to-back start edge is still caught
                    if (clk_bps) begin
                        r_state    <= S_IDLE;
                        bps_start  <= 1'b0;
                        rx_busy    <= 1'b0;
                        frame_err  <= ~r_sync2;
                        parity_err <= w_par_bad;
                        if (r_sync2 && !w_par_bad) begin
                            rx_data <= r_shift;
                            rx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    bps_start <= 1'b0;
                    rx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - bench for uart_rx_ctrl: 8N1 and 8E1 instances with a local baud generator
module tb_uart_rx_ctrl;

    localparam int BIT  = 16;
    localparam int HALF = BIT / 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      rx_line = 2'b11;
    logic [1:0]      clk_bps;
    logic [1:0]      bps_start;
    logic [1:0]      rx_done;
    logic [1:0]      frame_err;
    logic [1:0]      parity_err;
    logic [1:0]      rx_busy;
    logic [1:0][7:0] rx_data;

    int bcnt [2]   = '{0, 0};
    int n_done [2] = '{0, 0};
    int n_fe [2]   = '{0, 0};
    int n_pe [2]   = '{0, 0};
    int n_starts0  = 0;
    int hi_run0    = 0;
    int last_hi0   = 0;
    logic prev_bps0 = 1'b0;
    logic [7:0] got0 [$];
    logic [7:0] last_data [2];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_done;
        logic       exp_fe;
        logic [7:0] exp_data;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_line[0]), .clk_bps(clk_bps[0]),
        .bps_start(bps_start[0]), .rx_data(rx_data[0]), .rx_done(rx_done[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .rx_busy(rx_busy[0])
    );

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_line[1]), .clk_bps(clk_bps[1]),
        .bps_start(bps_start[1]), .rx_data(rx_data[1]), .rx_done(rx_done[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .rx_busy(rx_busy[1])
    );

    // Baud generator: counts from 0 while enabled, pulses once mid-bit
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!bps_start[i]) bcnt[i] <= 0;
            else               bcnt[i] <= (bcnt[i] == BIT - 1) ? 0 : bcnt[i] + 1;
        end
    end
    assign clk_bps[0] = bps_start[0] && (bcnt[0] == HALF);
    assign clk_bps[1] = bps_start[1] && (bcnt[1] == HALF);

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rx_done[i])    n_done[i] <= n_done[i] + 1;
            if (frame_err[i])  n_fe[i]   <= n_fe[i] + 1;
            if (parity_err[i]) n_pe[i]   <= n_pe[i] + 1;
        end
        if (rx_done[0]) got0.push_back(rx_data[0]);
        if (bps_start[0] && !prev_bps0) n_starts0 <= n_starts0 + 1;
        if (bps_start[0]) hi_run0 <= hi_run0 + 1;
        else if (hi_run0 != 0) begin
            last_hi0 <= hi_run0;
            hi_run0  <= 0;
        end
        prev_bps0 <= bps_start[0];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int w, input logic b);
        rx_line[w] = b;
        wait_cyc(BIT);
    endtask

    task automatic drive_frame(input int w, input logic [7:0] d, input logic use_par,
                               input logic par, input logic stop);
        drive_bit(w, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
        if (use_par) drive_bit(w, par);
        drive_bit(w, stop);
    endtask

    task automatic wait_idle(input int w);
        int k = 0;
        while (bps_start[w] && k < 4 * BIT) begin
            wait_cyc(1);
            k++;
        end
        check("idle_timeout", 32'(bps_start[w]), 32'd0);
    endtask

    function automatic logic par_even(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 1;
    endfunction

    // Reference: a frame completes only with a high stop bit and (if used) a matching parity bit
    task automatic run_frame(input string tag, input int w, input logic [7:0] d,
                             input logic par, input logic stop);
        int d0 = n_done[w];
        int f0 = n_fe[w];
        int p0 = n_pe[w];
        logic use_par, ep, ef, ed;
        use_par = (w == 1);
        drive_frame(w, d, use_par, par, stop);
        rx_line[w] = 1'b1;
        wait_cyc(3);
        wait_idle(w);
        ep = use_par && (par != par_even(d));
        ef = !stop;
        ed = stop && !ep;
        if (ed) last_data[w] = d;
        check({tag, "/done"}, 32'(n_done[w] - d0), 32'(ed));
        check({tag, "/ferr"}, 32'(n_fe[w] - f0), 32'(ef));
        check({tag, "/perr"}, 32'(n_pe[w] - p0), 32'(ep));
        check({tag, "/data"}, 32'(rx_data[w]), 32'(last_data[w]));
    endtask

    initial begin
        int d0, f0, p0, s0;
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[2] = '{8'h5F, 1'b1, 1'b1, 1'b0, 8'h5F};
        tbl[3] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'h5F};
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;

        wait_cyc(5);
        for (int w = 0; w < 2; w++) begin
            check("rst/rx_data", 32'(rx_data[w]), 32'd0);
            check("rst/bps_start", 32'(bps_start[w]), 32'd0);
            check("rst/rx_done", 32'(rx_done[w]), 32'd0);
            check("rst/frame_err", 32'(frame_err[w]), 32'd0);
            check("rst/parity_err", 32'(parity_err[w]), 32'd0);
            check("rst/rx_busy", 32'(rx_busy[w]), 32'd0);
        end
        rst_n = 1'b1;
        wait_cyc(5);

        for (int i = 0; i < 4; i++) begin
            d0 = n_done[0];
            f0 = n_fe[0];
            drive_frame(0, tbl[i].d, 1'b0, 1'b0, tbl[i].stop);
            rx_line[0] = 1'b1;
            wait_cyc(3);
            wait_idle(0);
            check("tbl/done", 32'(n_done[0] - d0), 32'(tbl[i].exp_done));
            check("tbl/ferr", 32'(n_fe[0] - f0), 32'(tbl[i].exp_fe));
            check("tbl/data", 32'(rx_data[0]), 32'(tbl[i].exp_data));
            check_range("tbl/bps_len", last_hi0, 9 * BIT, 10 * BIT);
        end
        last_data[0] = 8'h5F;

        got0.delete();
        drive_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        rx_line[0] = 1'b1;
        wait_cyc(3);
        wait_idle(0);
        check("b2b/count", 32'(got0.size()), 32'd2);
        check("b2b/first", 32'(got0[0]), 32'h00);
        check("b2b/second", 32'(got0[1]), 32'hFF);
        last_data[0] = 8'hFF;

        d0 = n_done[0]; f0 = n_fe[0]; p0 = n_pe[0];
        rx_line[0] = 1'b0;
        wait_cyc(4);
        rx_line[0] = 1'b1;
        wait_cyc(3 * BIT);
        check("glitch/done", 32'(n_done[0] - d0), 32'd0);
        check("glitch/ferr", 32'(n_fe[0] - f0), 32'd0);
        check("glitch/perr", 32'(n_pe[0] - p0), 32'd0);
        check("glitch/busy", 32'(rx_busy[0]), 32'd0);
        check_range("glitch/bps_len", last_hi0, BIT / 4, BIT);

        d0 = n_done[0]; f0 = n_fe[0]; s0 = n_starts0;
        drive_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        wait_cyc(3 * BIT);
        check("break/ferr", 32'(n_fe[0] - f0), 32'd1);
        check("break/starts", 32'(n_starts0 - s0), 32'd1);
        check("break/done", 32'(n_done[0] - d0), 32'd0);
        check("break/bps", 32'(bps_start[0]), 32'd0);
        rx_line[0] = 1'b1;
        wait_cyc(BIT);
        run_frame("after_break", 0, 8'h42, 1'b0, 1'b1);

        run_frame("par_bad", 1, 8'h07, 1'b0, 1'b1);
        run_frame("par_good", 1, 8'h07, 1'b1, 1'b1);
        run_frame("par_both", 1, 8'h07, 1'b0, 1'b0);
        run_frame("par_stop", 1, 8'h18, 1'b0, 1'b0);

        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, (8'h5A >> i) & 1'b1);
        rx_line[0] = 1'b1;
        wait_cyc(HALF);
        check("mid/bps", 32'(bps_start[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst/rx_data", 32'(rx_data[0]), 32'd0);
        check("mid_rst/bps_start", 32'(bps_start[0]), 32'd0);
        check("mid_rst/rx_busy", 32'(rx_busy[0]), 32'd0);
        check("mid_rst/flags", 32'({rx_done[0], frame_err[0], parity_err[0]}), 32'd0);
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        wait_cyc(2 * BIT);
        d0 = n_done[0]; f0 = n_fe[0]; p0 = n_pe[0];
        rst_n = 1'b1;
        wait_cyc(2 * BIT);
        check("post_rst/quiet", 32'((n_done[0] - d0) + (n_fe[0] - f0) + (n_pe[0] - p0)), 32'd0);
        check("post_rst/busy", 32'(rx_busy[0]), 32'd0);
        run_frame("post_rst", 0, 8'h5A, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            int w;
            logic [7:0] d;
            logic stop, par;
            w    = i % 2;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = par_even(d) ^ ($urandom_range(0, 3) == 0);
            run_frame("rand", w, d, par, stop);
            wait_cyc($urandom_range(0, BIT));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
